vram_scheduler: RTL and testbench

Time-slot scheduler that shares the single-port 16-bit video memory between the 4-cycle glyph-generator pixel pipeline and a CPU/console read-write port. It sits between the VGA timing block, the glyph generator, the memory and the CPU bus. Every 4-cycle pixel slot it starts one glyph lookup, gives the glyph generator the memory address bus in the two cycles it reads, and grants CPU accesses in the remaining cycles. It registers the resulting pixel colour for the VGA output.

---
 rtl/vram_pkg.sv | 19 +
 rtl/vram_cpu_port.sv | 40 ++++
 rtl/vram_scheduler.sv | 93 +++++++++
 tb/tb_vram_scheduler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared constants and types for the video-memory time-slot scheduler.
package vram_pkg;

    localparam int ADDR_WIDTH_DEF = 15;
    localparam int DATA_WIDTH_DEF = 16;

    localparam logic [1:0] PH_START = 2'd0;
    localparam logic [1:0] PH_CHAR  = 2'd1;
    localparam logic [1:0] PH_GLYPH = 2'd2;
    localparam logic [1:0] PH_CPU   = 2'd3;

    typedef enum logic {
        BLANK  = 1'b0,
        ACTIVE = 1'b1
    } slot_mode_e;

    localparam logic [14:0] GLYPH_BASE = 15'h2000;

endpackage

// File: rtl/vram_cpu_port.sv
// CPU side of the VRAM scheduler: single-outstanding access with 1-cycle ack.
// Latency: grant to ack 1 cycle; read data comes straight from memory during ack.
// Backpressure: cpu_req is held until cpu_ack; no new grant while busy or acking.
module vram_cpu_port #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  eligible,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  grant,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata
);

    logic                  busy;
    logic                  rd_pend;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Reset suppresses both a new grant and the ack of an access in flight.
    assign grant     = eligible & cpu_req & ~busy & ~cpu_ack & ~rst;
    assign cpu_ack   = busy & ~rst;
    assign cpu_rdata = (cpu_ack && rd_pend) ? mem_rdata : rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            rd_pend <= 1'b0;
            rdata_q <= '0;
        end else begin
            busy    <= grant;
            rd_pend <= grant & ~cpu_we;
            if (busy && rd_pend)
                rdata_q <= mem_rdata;
        end
    end

endmodule

// File: rtl/vram_scheduler.sv
// Shares single-port VRAM between the 4-cycle glyph pipeline and the CPU port.
// Latency: pixel 4 cycles after sampling; CPU grant-to-ack 1 cycle.
// Backpressure: display never stalls; CPU waits for phase 3 (or BLANK phase 1 with VRAM_SCHED_BLANK_BOOST_EN).
module vram_scheduler
    import vram_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_active,
    input  logic [9:0]            pix_col,
    input  logic [8:0]            pix_row,
    output logic                  gg_req,
    output logic [9:0]            gg_col,
    output logic [8:0]            gg_row,
    input  logic [ADDR_WIDTH-1:0] gg_addr,
    input  logic [7:0]            gg_color,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic [7:0]            pixel_color
);

    logic [1:0] phase;
    slot_mode_e mode;
    logic       boost_ok;
    logic       eligible;
    logic       grant;

`ifdef VRAM_SCHED_BLANK_BOOST_EN
    assign boost_ok = (phase == PH_CHAR) && (mode == BLANK);
`else
    assign boost_ok = 1'b0;
`endif

    assign eligible = (phase == PH_CPU) || boost_ok;

    assign gg_req = (phase == PH_START) && pix_active;
    assign gg_col = pix_col;
    assign gg_row = pix_row;

    // Mode of the finishing slot decides the captured colour before it is overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase       <= PH_START;
            mode        <= BLANK;
            pixel_color <= 8'd0;
        end else begin
            phase <= phase + 2'd1;
            if (phase == PH_START) begin
                mode        <= pix_active ? ACTIVE : BLANK;
                pixel_color <= (mode == ACTIVE) ? gg_color : 8'd0;
            end
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (grant) begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we;
            mem_wdata = cpu_wdata;
        end else if (mode == ACTIVE && (phase == PH_CHAR || phase == PH_GLYPH)) begin
            mem_addr = gg_addr;
        end
    end

    vram_cpu_port #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_cpu_port (
        .clk      (clk),
        .rst      (rst),
        .eligible (eligible),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .mem_rdata(mem_rdata),
        .grant    (grant),
        .cpu_ack  (cpu_ack),
        .cpu_rdata(cpu_rdata)
    );

endmodule

// File: tb/tb_vram_scheduler.sv
// Scoreboard bench for vram_scheduler: stimulus queues expected acks/writes, a negedge monitor checks them.
module tb_vram_scheduler;
    import vram_pkg::*;

`ifdef VRAM_SCHED_BLANK_BOOST_EN
    localparam bit BOOST = 1'b1;
`else
    localparam bit BOOST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_active;
    logic [9:0]  pix_col;
    logic [8:0]  pix_row;
    logic        gg_req;
    logic [9:0]  gg_col;
    logic [8:0]  gg_row;
    logic [14:0] gg_addr;
    logic [7:0]  gg_color;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        cpu_req;
    logic        cpu_we;
    logic [14:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic [7:0]  pixel_color;

    vram_scheduler dut (
        .clk(clk), .rst(rst),
        .pix_active(pix_active), .pix_col(pix_col), .pix_row(pix_row),
        .gg_req(gg_req), .gg_col(gg_col), .gg_row(gg_row),
        .gg_addr(gg_addr), .gg_color(gg_color),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .pixel_color(pixel_color)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit started  = 1'b0;
    logic [15:0] rd_hold = 16'h0000;

    // Reference model of slot phase, mode and captured colour.
    logic [1:0] ph_m   = 2'd0;
    logic       mode_m = 1'b0;
    logic [7:0] pix_m  = 8'd0;

    // Memory and glyph-generator models.
    logic [15:0] mem [0:32767];
    logic [9:0]  gg_lat = 10'd0;
    assign gg_addr  = GLYPH_BASE + {5'd0, gg_lat};
    assign gg_color = 8'hA5;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
        if (gg_req) gg_lat <= gg_col;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            ph_m   <= 2'd0;
            mode_m <= 1'b0;
            pix_m  <= 8'd0;
        end else begin
            ph_m <= ph_m + 2'd1;
            if (ph_m == 2'd0) begin
                mode_m <= pix_active;
                pix_m  <= mode_m ? 8'hA5 : 8'h00;
            end
        end
    end

    typedef struct { int cyc; logic [15:0] rdata; } ack_t;
    typedef struct { int cyc; logic [14:0] addr; logic [15:0] data; } wr_t;
    ack_t ack_q[$];
    wr_t  wr_q[$];
    ack_t ea;
    wr_t  ew;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (started && !rst) begin
            chk("gg_req", 32'(gg_req), 32'((ph_m == 2'd0) && pix_active));
            if (gg_req) begin
                chk("gg_col", 32'(gg_col), 32'(pix_col));
                chk("gg_row", 32'(gg_row), 32'(pix_row));
            end
            chk("pixel_color", 32'(pixel_color), 32'(pix_m));
            if (mode_m && (ph_m == 2'd1 || ph_m == 2'd2)) begin
                chk("disp_addr", 32'(mem_addr), 32'(gg_addr));
                chk("disp_we", 32'(mem_we), 32'd0);
            end
            if (!mode_m && (ph_m == 2'd2 || (!BOOST && ph_m == 2'd1)))
                chk("idle_addr", 32'(mem_addr), 32'd0);
            if (cpu_ack) begin
                if (ack_q.size() == 0) begin
                    chk("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    ea = ack_q.pop_front();
                    chk("ack_cycle", 32'(cyc), 32'(ea.cyc));
                    chk("cpu_rdata", 32'(cpu_rdata), 32'(ea.rdata));
                end
            end
            if (mem_we) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_we", 32'd1, 32'd0);
                end else begin
                    ew = wr_q.pop_front();
                    chk("we_cycle", 32'(cyc), 32'(ew.cyc));
                    chk("we_addr", 32'(mem_addr), 32'(ew.addr));
                    chk("we_data", 32'(mem_wdata), 32'(ew.data));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic align(input logic [1:0] p);
        int n = 0;
        while (ph_m != p && n < 8) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_ack();
        int n   = 0;
        bit got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            if (cpu_ack) got = 1'b1;
            n++;
        end
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
        tick();
    endtask

    // lat = cycles from the cycle the request is raised to the ack cycle.
    task automatic cpu_op(input logic we, input logic [14:0] a, input logic [15:0] d,
                          input int lat, input logic [15:0] exp_rd);
        ack_q.push_back('{cyc + lat, exp_rd});
        if (we) wr_q.push_back('{cyc + lat - 1, a, d});
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        wait_ack();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
        mem[15'h0020] = 16'h1234;
        mem[15'h0021] = 16'h5678;
        rst = 1'b1; pix_active = 1'b0; pix_col = 10'd0; pix_row = 9'd0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 15'd0; cpu_wdata = 16'd0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_ack", 32'(cpu_ack), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_pixel", 32'(pixel_color), 32'd0);
        chk("rst_rdata", 32'(cpu_rdata), 32'd0);
        tick();

        // Active-only stream: first sample at end of this phase-0 cycle.
        pix_active = 1'b1; pix_col = 10'd8; pix_row = 9'd0;
        rst = 1'b0; started = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        chk("pix_before", 32'(pixel_color), 32'd0);
        tick();
        @(negedge clk);
        chk("pix_first", 32'(pixel_color), 32'hA5);
        repeat (6) tick();

        // CPU write raised in phase 1 of an ACTIVE slot: grant phase 3, ack phase 0.
        align(2'd1);
        cpu_op(1'b1, 15'h0010, 16'hBEEF, 3, rd_hold);
        cpu_req = 1'b0;
        // Worst-ish case: raised in phase 0, grant phase 3.
        align(2'd0);
        cpu_op(1'b0, 15'h0010, 16'h0000, 4, 16'hBEEF);
        cpu_req = 1'b0; rd_hold = 16'hBEEF;

        // Back-to-back reads in BLANK slots.
        pix_active = 1'b0;
        align(2'd0);
        tick();
        cpu_op(1'b0, 15'h0020, 16'h0000, BOOST ? 1 : 3, 16'h1234);
        cpu_op(1'b0, 15'h0021, 16'h0000, BOOST ? 1 : 3, 16'h5678);
        cpu_req = 1'b0; rd_hold = 16'h5678;
        repeat (3) tick();

        // BLANK phase-3 read while display resumes: ack and gg_req share phase 0.
        align(2'd3);
        pix_active = 1'b1;
        cpu_op(1'b0, 15'h0020, 16'h0000, 1, 16'h1234);
        cpu_req = 1'b0; rd_hold = 16'h1234;
        @(negedge clk);
        chk("b2a_addr", 32'(mem_addr), 32'h2008);
        tick();

        // Reset during the ack cycle drops the ack; request then re-granted.
        align(2'd3);
        wr_q.push_back('{cyc, 15'h0030, 16'hCAFE});
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0030; cpu_wdata = 16'hCAFE;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_drop_ack", 32'(cpu_ack), 32'd0);
        chk("rst_cycle_we", 32'(mem_we), 32'd0);
        tick();
        rst = 1'b0; rd_hold = 16'h0000;
        ack_q.push_back('{cyc + 4, rd_hold});
        wr_q.push_back('{cyc + 3, 15'h0030, 16'hCAFE});
        @(negedge clk);
        chk("post_rst_pixel", 32'(pixel_color), 32'd0);
        chk("post_rst_ack", 32'(cpu_ack), 32'd0);
        wait_ack();
        cpu_req = 1'b0;

        align(2'd2);
        cpu_op(1'b0, 15'h0030, 16'h0000, 2, 16'hCAFE);
        cpu_req = 1'b0;

        repeat (8) tick();
        chk("ack_q_empty", 32'(ack_q.size()), 32'd0);
        chk("wr_q_empty", 32'(wr_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
